// File: rtl/hex_score_driver.sv
// Avalon-MM score register driving six 7-segment displays. A written binary
// value is converted to BCD by a serial shift-add-3 engine, then segment-encoded.
module hex_score_driver #(
  parameter int VALUE_W    = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W);
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(999999);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t             state;
  logic [VALUE_W-1:0] value_q, bin_q, wr_val;
  logic [BCD_W-1:0]   bcd_q, bcd_adj, digits_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               lzb_q, en_q, wr_en;
  logic [NUM_DIGITS-1:0]      hi_zero;
  logic [NUM_DIGITS-1:0][6:0] seg;

  assign wr_en  = chipselect & ~write_n;
  assign wr_val = (writedata[VALUE_W-1:0] > MAX_VAL) ? MAX_VAL : writedata[VALUE_W-1:0];
  assign busy   = (state != IDLE);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      value_q  <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      lzb_q    <= 1'b1;
      en_q     <= 1'b1;
    end else begin
      if (wr_en && address == 2'd2) {en_q, lzb_q} <= writedata[1:0];
      // A VALUE write always (re)starts; any conversion in flight is dropped.
      if (wr_en && address == 2'd0) begin
        value_q <= wr_val;
        state   <= LOAD;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            bcd_q <= '0;
            bin_q <= value_q;
            cnt_q <= CNT_W'(VALUE_W - 1);
            state <= SHIFT;
          end
          SHIFT: begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state <= UPDATE;
          end
          UPDATE: begin
            digits_q <= bcd_q;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // hi_zero[k]: digit k and every digit above it are zero.
  always_comb begin
    logic z;
    z       = 1'b1;
    hi_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z          = z & (digits_q[4*k +: 4] == 4'd0);
      hi_zero[k] = z;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!en_q || (lzb_q && k != 0 && hi_zero[k])) seg[k] = 7'h7F;
      else                                          seg[k] = seg7(digits_q[4*k +: 4]);
    end
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

  always_comb begin
    case (address)
      2'd0:    readdata = 32'(value_q);
      2'd1:    readdata = {31'b0, busy};
      2'd2:    readdata = {30'b0, en_q, lzb_q};
      default: readdata = '0;
    endcase
  end

endmodule
